// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-cycle core: gates the core clock-enable
// for free-run, pause, single-step, PC breakpoint and halt-opcode stop.
module cpu_run_ctrl #(
  parameter int unsigned          WIDTH   = 8,
  parameter int unsigned          CNT_W   = 16,
  parameter logic [WIDTH-1:0]     HALT_OP = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             bp_en,
  input  logic [WIDTH-1:0] bp_addr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] instr,
  output logic             cpu_en,
  output logic [2:0]       state,
  output logic             bp_hit,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_BREAK  = 3'd3,
    S_HALTED = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             skip_q, skip_d;
  logic             ret_brk_q, ret_brk_d;
  logic             start_prev_q, step_prev_q;
  logic             bp_hit_q, halted_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic hop, bpm, start_rise, step_rise, en_c;

  always_comb begin
    hop        = (instr == HALT_OP);
    bpm        = bp_en && (pc == bp_addr) && !skip_q;
    start_rise = start && !start_prev_q;
    step_rise  = step && !step_prev_q;

    state_d   = state_q;
    skip_d    = skip_q;
    ret_brk_d = ret_brk_q;
    en_c      = 1'b0;

    case (state_q)
      S_IDLE, S_BREAK: begin
        // Leaving BREAK arms skip_bp so the resume executes the instruction at bp_addr.
        if (!stop && (step_rise || start_rise)) begin
          state_d   = step_rise ? S_STEP : S_RUN;
          skip_d    = (state_q == S_BREAK);
          ret_brk_d = (state_q == S_BREAK);
        end
      end
      S_RUN: begin
        if (hop)       state_d = S_HALTED;
        else if (bpm)  state_d = S_BREAK;
        else if (stop) state_d = S_IDLE;
        else           en_c    = 1'b1;
      end
      S_STEP: begin
        if (hop) begin
          state_d = S_HALTED;
        end else begin
          en_c    = 1'b1;
          state_d = ret_brk_q ? S_BREAK : S_IDLE;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase

    if (en_c) skip_d = 1'b0;

    cnt_d = cnt_q;
    if (en_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    start_prev_q <= start;
    step_prev_q  <= step;
    if (rst) begin
      state_q   <= S_IDLE;
      skip_q    <= 1'b0;
      ret_brk_q <= 1'b0;
      bp_hit_q  <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      ret_brk_q <= ret_brk_d;
      bp_hit_q  <= (state_d == S_BREAK);
      halted_q  <= (state_d == S_HALTED);
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_en    = en_c;
  assign state     = state_q;
  assign bp_hit    = bp_hit_q;
  assign halted    = halted_q;
  assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: tiny core stub (pc/program ROM), directed scenarios,
// then random stimulus checked against a behavioural run-control model.
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, stop, step, bp_en;
  logic [7:0]  bp_addr, pc, instr;
  logic        cpu_en, bp_hit, halted;
  logic [2:0]  state;
  logic [15:0] cycle_cnt;
  logic        cpu_en4, bp_hit4, halted4;
  logic [2:0]  state4;
  logic [3:0]  cnt4;
  logic [7:0]  mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  // model of the run controller
  int m_mode;
  bit m_skip, m_from_brk, m_sprev, m_stprev;
  int m_cnt;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.WIDTH(8), .CNT_W(16), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
    .cpu_en(cpu_en), .state(state), .bp_hit(bp_hit), .halted(halted),
    .cycle_cnt(cycle_cnt)
  );

  cpu_run_ctrl #(.WIDTH(8), .CNT_W(4), .HALT_OP(8'hFF)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .instr(instr),
    .cpu_en(cpu_en4), .state(state4), .bp_hit(bp_hit4), .halted(halted4),
    .cycle_cnt(cnt4)
  );

  // core stub: commits (pc advance) only when enabled
  always_ff @(posedge clk) begin
    if (rst)         pc <= 8'd0;
    else if (cpu_en) pc <= pc + 8'd1;
  end
  assign instr = mem[pc];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic cycle();
    bit hop, bpm, en, start_r, step_r;
    #1;
    hop = (instr == 8'hFF);
    bpm = bp_en && (pc == bp_addr) && !m_skip;
    en  = (m_mode == 1 && !hop && !bpm && !stop) || (m_mode == 2 && !hop);

    chk("cpu_en",    32'(cpu_en),    32'(en));
    chk("state",     32'(state),     32'(m_mode));
    chk("bp_hit",    32'(bp_hit),    32'(m_mode == 3));
    chk("halted",    32'(halted),    32'(m_mode == 4));
    chk("cycle_cnt", 32'(cycle_cnt), (m_cnt > 65535) ? 32'd65535 : 32'(m_cnt));
    chk("cpu_en4",   32'(cpu_en4),   32'(en));
    chk("state4",    32'(state4),    32'(m_mode));
    chk("cnt4_sat",  32'(cnt4),      (m_cnt > 15) ? 32'd15 : 32'(m_cnt));

    start_r = start && !m_sprev;
    step_r  = step && !m_stprev;
    if (rst) begin
      m_mode = 0; m_skip = 0; m_from_brk = 0; m_cnt = 0;
    end else begin
      if (m_mode == 0 || m_mode == 3) begin
        if (!stop && (step_r || start_r)) begin
          m_from_brk = (m_mode == 3);
          m_skip     = (m_mode == 3);
          m_mode     = step_r ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (hop)       m_mode = 4;
        else if (bpm)  m_mode = 3;
        else if (stop) m_mode = 0;
      end else if (m_mode == 2) begin
        m_mode = hop ? 4 : (m_from_brk ? 3 : 0);
      end
      if (en) begin
        m_cnt++;
        m_skip = 0;
      end
    end
    m_sprev  = start;
    m_stprev = step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; cycle(); rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0;
    bp_en = 1'b0; bp_addr = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    m_mode = 0; m_skip = 0; m_from_brk = 0; m_sprev = 0; m_stprev = 0; m_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle();
    rst = 1'b0;

    // reset mid-RUN
    pulse_start();
    repeat (5) cycle();
    chk("run5_cnt", 32'(cycle_cnt), 32'd5);
    pulse_rst();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cnt",   32'(cycle_cnt), 32'd0);
    chk("rst_en",    32'(cpu_en), 32'd0);

    // free-run then stop
    pulse_start();
    repeat (10) cycle();
    stop = 1'b1;
    cycle();
    chk("stop_cnt",   32'(cycle_cnt), 32'd10);
    chk("stop_state", 32'(state), 32'd0);
    repeat (3) cycle();
    chk("stop_pc_frozen", 32'(pc), 32'd10);
    stop = 1'b0;

    // breakpoint at 05, then resume past it
    pulse_rst();
    bp_en = 1'b1; bp_addr = 8'h05;
    pulse_start();
    repeat (8) cycle();
    chk("bp_pc",    32'(pc), 32'd5);
    chk("bp_hit",   32'(bp_hit), 32'd1);
    chk("bp_state", 32'(state), 32'd3);
    pulse_start();
    repeat (4) cycle();
    chk("resume_pc",    32'(pc), 32'd9);
    chk("resume_state", 32'(state), 32'd1);
    stop = 1'b1; cycle(); stop = 1'b0;

    // single step from IDLE, held level gives one pulse
    step = 1'b1;
    repeat (4) cycle();
    step = 1'b0;
    cycle();
    chk("step1_pc",  32'(pc), 32'd10);
    chk("step1_cnt", 32'(cycle_cnt), 32'd10);
    step = 1'b1; cycle(); step = 1'b0;
    repeat (2) cycle();
    chk("step2_pc",  32'(pc), 32'd11);
    chk("step2_cnt", 32'(cycle_cnt), 32'd11);

    // step out of BREAK returns to BREAK
    pulse_rst();
    pulse_start();
    repeat (8) cycle();
    step = 1'b1; cycle(); step = 1'b0;
    repeat (3) cycle();
    chk("brkstep_pc",    32'(pc), 32'd6);
    chk("brkstep_state", 32'(state), 32'd3);
    chk("brkstep_cnt",   32'(cycle_cnt), 32'd6);

    // halt opcode at 03 is sticky until reset
    pulse_rst();
    bp_en = 1'b0;
    mem[3] = 8'hFF;
    pulse_start();
    repeat (6) cycle();
    chk("halt_pc",    32'(pc), 32'd3);
    chk("halt_flag",  32'(halted), 32'd1);
    for (int i = 0; i < 20; i++) begin
      start = (i % 2) == 0;
      step  = (i % 4) < 2;
      cycle();
    end
    start = 1'b0; step = 1'b0;
    chk("halt_pc_hold", 32'(pc), 32'd3);
    chk("halt_state",   32'(state), 32'd4);
    pulse_rst();
    chk("halt_cleared", 32'(halted), 32'd0);
    mem[3] = 8'h00;

    // simultaneous stop+step+start in IDLE
    stop = 1'b1; step = 1'b1; start = 1'b1;
    cycle();
    chk("all3_state", 32'(state), 32'd0);
    chk("all3_pc",    32'(pc), 32'd0);
    stop = 1'b0; step = 1'b0; start = 1'b0;
    cycle();

    // 4-bit counter saturation
    pulse_start();
    repeat (20) cycle();
    chk("sat_cnt4",  32'(cnt4), 32'd15);
    chk("sat_cnt16", 32'(cycle_cnt), 32'd20);
    stop = 1'b1; cycle(); stop = 1'b0;

    // random phase
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 39) == 0) ? 8'hFF : 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 9) == 0);
      step  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) begin
        bp_en   = 1'($urandom);
        bp_addr = 8'($urandom_range(0, 15));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run-control sequencer for the single-cycle CPU core. It produces the core's clock-enable, so the core can free-run, pause, single-step, stop on a PC breakpoint, or stop permanently on a halt opcode. It sits between the top-level debug/control inputs and the core's enable input. It observes the core's pc and instr buses, and it counts executed cycles for the bench and the debug readout.

Parameters:
WIDTH, 8, width of pc, instr, bp_addr
CNT_W, 16, width of executed-cycle counter
HALT_OP, 8'hFF, instr encoding that stops the core permanently

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  level; begin/resume free-run
stop  input  1  level; pause free-run
step  input  1  level; execute exactly one instruction
bp_en  input  1  breakpoint enable
bp_addr  input  WIDTH  breakpoint PC value
pc  input  WIDTH  current PC from core
instr  input  WIDTH  current instruction from core
cpu_en  output  1  core clock-enable; core commits state at a clk edge only when high
state  output  3  FSM state encoding
bp_hit  output  1  registered; high while in BREAK
halted  output  1  registered; high while in HALTED
cycle_cnt  output  CNT_W  number of cycles with cpu_en=1

Behaviour:
- Reset: one clk edge with rst=1 forces the following values: state=IDLE, cpu_en=0, bp_hit=0, halted=0, cycle_cnt=0, skip_bp=0.
- rst takes priority over everything, including mid-RUN and HALTED.
- State encoding: IDLE=0, RUN=1, STEP=2, BREAK=3, HALTED=4. Encodings 5-7 go to IDLE on the next edge.
- Match terms (combinational):
  - hop = (instr==HALT_OP)
  - bpm = bp_en && (pc==bp_addr) && !skip_bp
- cpu_en is combinational. It is high only in these cases:
  - state=RUN && !hop && !bpm && !stop
  - state=STEP && !hop
- IDLE / BREAK transitions (priority stop > step > start):
  - stop → stay.
  - step → STEP.
  - start → RUN.
  - Leaving BREAK sets skip_bp=1.
  - Leaving IDLE sets skip_bp=0.
- RUN transitions (priority hop > bpm > stop):
  - hop → HALTED.
  - bpm → BREAK.
  - stop → IDLE.
  - Otherwise stay; the instruction executes.
  - skip_bp clears after the first cpu_en=1 cycle, so resuming from a breakpoint executes the instruction at bp_addr once.
- STEP transitions:
  - hop → HALTED, instruction not executed.
  - Otherwise cpu_en=1 for exactly that cycle, then → previous pause state (IDLE, or BREAK if entered from BREAK).
  - Breakpoints are ignored in STEP.
  - A held step level does not re-trigger. A new step requires step=0 for at least one cycle (edge-detected internally; start is likewise edge-detected).
- HALTED: sticky, cpu_en=0. Exits only on rst.
- bp_hit = (state==BREAK). halted = (state==HALTED). Both are registered, valid one cycle after entry.
- cycle_cnt:
  - Increments by 1 at each edge where cpu_en=1.
  - Saturates at all-ones (no wrap).
  - Not cleared by start, stop, or step.
- Latency:
  - start pulse at edge N → RUN at N; cpu_en high during cycle N+1.
  - stop is effective combinationally in the same cycle (cpu_en drops before the edge).

Test Plan:
- Reset mid-RUN: start, run 5 cycles, assert rst 1 cycle → state=0, cpu_en=0, cycle_cnt=0 next cycle.
- Free-run then stop: start for 1 cycle, hold 10 cycles, stop → cycle_cnt=10, state=IDLE, pc frozen thereafter.
- Breakpoint:
  - bp_en=1, bp_addr=8'h05, start; pc reaches 05 → cpu_en=0 in that cycle, bp_hit=1 next cycle, pc stays 05.
  - Start again → pc advances past 05; no re-break at 05 on that pass.
- Single step: from IDLE hold step=1 for 4 cycles → exactly one cpu_en pulse, cycle_cnt +1.
  - Release, pulse step again → second pulse.
  - Step while in BREAK at pc=05 → pc moves to 06, back in BREAK.
- Halt opcode: program with instr=8'hFF at pc=03, start → cpu_en=0 at pc=03, halted=1, start/step ignored for 20 cycles; rst clears.
- Simultaneous stop+step+start in IDLE → stays IDLE, cpu_en=0. Counter saturation with CNT_W=4: run 20 cycles → cycle_cnt=4'hF.
